// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU result/flag stage.
//   - Flag bit positions inside the 4-bit NZCV vector ([0]=V .. [3]=N)
//   - cond_e : 4-bit condition codes (EQ..NV)
//   - buf_state_e : occupancy of the 2-entry write-back skid buffer
//   - wb_entry_t : one buffered write-back request {data, addr, we}
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_WIDTH  = 32;
    localparam int ALU_ADDR_W = 4;

    localparam int FLAG_V = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_CS = 4'd2,
        COND_CC = 4'd3,
        COND_MI = 4'd4,
        COND_PL = 4'd5,
        COND_VS = 4'd6,
        COND_VC = 4'd7,
        COND_HI = 4'd8,
        COND_LS = 4'd9,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_GT = 4'd12,
        COND_LE = 4'd13,
        COND_AL = 4'd14,
        COND_NV = 4'd15
    } cond_e;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    typedef struct packed {
        logic [ALU_WIDTH-1:0]  data;
        logic [ALU_ADDR_W-1:0] addr;
        logic                  we;
    } wb_entry_t;

endpackage : alu_pkg

// File: rtl/alu_result_stage_condition_checker.sv
// -----------------------------------------------------------------------------
// condition_checker
//   Purely combinational evaluation of a 4-bit condition code against the
//   architectural NZCV flags.
//   Ports:
//     cond      in  4  condition code (cond_e encoding)
//     nzcv      in  4  flags, [0]=V [1]=C [2]=Z [3]=N
//     cond_pass out 1  condition holds
// -----------------------------------------------------------------------------
module condition_checker
    import alu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       cond_pass
);

    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;

    assign flag_n = nzcv[FLAG_N];
    assign flag_z = nzcv[FLAG_Z];
    assign flag_c = nzcv[FLAG_C];
    assign flag_v = nzcv[FLAG_V];

    always_comb begin
        cond_pass = 1'b0;
        case (cond_e'(cond))
            COND_EQ: cond_pass = flag_z;
            COND_NE: cond_pass = ~flag_z;
            COND_CS: cond_pass = flag_c;
            COND_CC: cond_pass = ~flag_c;
            COND_MI: cond_pass = flag_n;
            COND_PL: cond_pass = ~flag_n;
            COND_VS: cond_pass = flag_v;
            COND_VC: cond_pass = ~flag_v;
            COND_HI: cond_pass = flag_c & ~flag_z;
            COND_LS: cond_pass = ~flag_c | flag_z;
            COND_GE: cond_pass = (flag_n == flag_v);
            COND_LT: cond_pass = (flag_n != flag_v);
            COND_GT: cond_pass = ~flag_z & (flag_n == flag_v);
            COND_LE: cond_pass = flag_z | (flag_n != flag_v);
            COND_AL: cond_pass = 1'b1;
            COND_NV: cond_pass = 1'b0;
            default: cond_pass = 1'b0;
        endcase
    end

endmodule : condition_checker

// File: rtl/alu_result_stage.sv
// -----------------------------------------------------------------------------
// alu_result_stage
//   Registered result/flag stage behind the ALU. Each accepted ALU result is
//   condition-checked against the architectural flags, optionally updates
//   those flags, and is queued as a write-back request in a 2-entry skid
//   buffer. The register file drains the buffer through a valid/ready pair.
//   Ports:
//     clk_i, rst_n_i          clock, asynchronous active-low reset
//     in_valid_i/in_ready_o   ALU-side handshake
//     result_i, flags_i       ALU result and its V/C/Z/N flags
//     rd_i, we_i              destination register and write intent
//     set_flags_i, cond_i     flag update enable, condition code
//     flush_i                 synchronous discard of buffered entries
//     out_valid_o/out_ready_i register-file-side handshake
//     wb_data_o/addr_o/we_o   oldest buffered write-back request
//     nzcv_o                  architectural flags, same order as flags_i
// -----------------------------------------------------------------------------
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [WIDTH-1:0]  result_i,
    input  logic [3:0]        flags_i,
    input  logic [ADDR_W-1:0] rd_i,
    input  logic              we_i,
    input  logic              set_flags_i,
    input  logic [3:0]        cond_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [WIDTH-1:0]  wb_data_o,
    output logic [ADDR_W-1:0] wb_addr_o,
    output logic              wb_we_o,
    output logic [3:0]        nzcv_o
);

    buf_state_e state_p0;
    logic       head_p0;
    wb_entry_t  entry_p0 [2];
    logic [3:0] nzcv_p0;

    logic       cond_pass;
    logic       accept;
    logic       pop;
    logic       wr_idx;
    logic       vld_p0;
    wb_entry_t  new_entry;
    wb_entry_t  head_entry;

    condition_checker u_condition_checker (
        .cond      (cond_i),
        .nzcv      (nzcv_p0),
        .cond_pass (cond_pass)
    );

    // Handshake decode: everything here depends on registered state only,
    // so in_ready_o and out_valid_o have no path from the ready/valid inputs.
    assign in_ready_o = (state_p0 != BUF_FULL);
    assign vld_p0     = (state_p0 != BUF_EMPTY);
    assign accept     = in_valid_i & in_ready_o & ~flush_i;
    assign pop        = vld_p0 & out_ready_i;

    // With one entry held, the new entry goes into the slot behind the head;
    // otherwise the buffer is empty and the head slot is free.
    assign wr_idx = (state_p0 == BUF_ONE) ? ~head_p0 : head_p0;

    assign new_entry.data = result_i;
    assign new_entry.addr = rd_i;
    assign new_entry.we   = we_i & cond_pass;

    // ---- stage p0: buffer occupancy, head pointer and flag register ----
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_p0 <= BUF_EMPTY;
            head_p0  <= 1'b0;
            nzcv_p0  <= 4'b0000;
        end else if (flush_i) begin
            // Flush wins over any same-cycle accept or pop; flags untouched.
            state_p0 <= BUF_EMPTY;
        end else begin
            if (accept && cond_pass && set_flags_i) begin
                nzcv_p0 <= flags_i;
            end
            case (state_p0)
                BUF_EMPTY: begin
                    if (accept) begin
                        state_p0 <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (pop) begin
                        head_p0 <= ~head_p0;
                    end
                    if (accept && !pop) begin
                        state_p0 <= BUF_FULL;
                    end else if (!accept && pop) begin
                        state_p0 <= BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    if (pop) begin
                        head_p0  <= ~head_p0;
                        state_p0 <= BUF_ONE;
                    end
                end
                default: begin
                    state_p0 <= BUF_EMPTY;
                end
            endcase
        end
    end

    // ---- stage p0: entry storage ----
    // Entries are cleared on reset so the write-back outputs read zero.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            entry_p0[0] <= '0;
            entry_p0[1] <= '0;
        end else if (accept) begin
            entry_p0[wr_idx] <= new_entry;
        end
    end

    // ---- output decode from registered state ----
    assign head_entry  = entry_p0[head_p0];
    assign out_valid_o = vld_p0;
    assign wb_data_o   = head_entry.data;
    assign wb_addr_o   = head_entry.addr;
    assign wb_we_o     = head_entry.we;
    assign nzcv_o      = nzcv_p0;

endmodule : alu_result_stage

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] result;
    logic [3:0]  flags;
    logic [3:0]  rd;
    logic        we;
    logic        set_flags;
    logic [3:0]  cond;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] wb_data;
    logic [3:0]  wb_addr;
    logic        wb_we;
    logic [3:0]  nzcv;

    int vectors;
    int miscompares;

    alu_result_stage #(.WIDTH(32), .ADDR_W(4)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .result_i    (result),
        .flags_i     (flags),
        .rd_i        (rd),
        .we_i        (we),
        .set_flags_i (set_flags),
        .cond_i      (cond),
        .flush_i     (flush),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .wb_data_o   (wb_data),
        .wb_addr_o   (wb_addr),
        .wb_we_o     (wb_we),
        .nzcv_o      (nzcv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] res, input logic [3:0] fl,
                         input logic [3:0] r, input logic w, input logic sf, input logic [3:0] c);
        in_valid  = v;
        result    = res;
        flags     = fl;
        rd        = r;
        we        = w;
        set_flags = sf;
        cond      = c;
    endtask

    logic [15:0] pass_a;
    logic [15:0] pass_b;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        flush       = 1'b0;
        out_ready   = 1'b1;
        drive(1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'd14);
        // nzcv = N,C set : expected pass per cond index 0..15
        pass_a = 16'h6996;
        // nzcv = Z,V set
        pass_b = 16'h6A69;

        #3;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_nzcv", nzcv, 4'b0000);
        check("rst_wb_data", wb_data, 32'h0);
        check("rst_wb_addr", wb_addr, 4'h0);
        check("rst_wb_we", wb_we, 1'b0);
        #9 rst_n = 1'b1;
        tick();
        check("rst_in_ready", in_ready, 1'b1);

        // Single AL op
        drive(1'b1, 32'h0000_00A5, 4'h0, 4'd3, 1'b1, 1'b0, 4'd14);
        tick();
        drive(1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'd14);
        check("al_valid", out_valid, 1'b1);
        check("al_data", wb_data, 32'hA5);
        check("al_addr", wb_addr, 4'd3);
        check("al_we", wb_we, 1'b1);
        check("al_nzcv", nzcv, 4'b0000);
        tick();
        check("al_drained", out_valid, 1'b0);

        // Flag chain: SUBS sets Z, then EQ passes, NE fails
        drive(1'b1, 32'h0, 4'b0100, 4'd1, 1'b1, 1'b1, 4'd14);
        tick();
        check("subs_nzcv", nzcv, 4'b0100);
        check("subs_addr", wb_addr, 4'd1);
        drive(1'b1, 32'h55, 4'b0000, 4'd5, 1'b1, 1'b0, 4'd0);
        tick();
        check("eq_addr", wb_addr, 4'd5);
        check("eq_data", wb_data, 32'h55);
        check("eq_we", wb_we, 1'b1);
        drive(1'b1, 32'h66, 4'b1111, 4'd6, 1'b1, 1'b1, 4'd1);
        tick();
        check("ne_valid", out_valid, 1'b1);
        check("ne_addr", wb_addr, 4'd6);
        check("ne_we", wb_we, 1'b0);
        check("ne_nzcv_kept", nzcv, 4'b0100);
        drive(1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'd14);
        tick();
        check("chain_drained", out_valid, 1'b0);

        // Backpressure: three ops with the register file stalled
        out_ready = 1'b0;
        drive(1'b1, 32'h11, 4'h0, 4'd1, 1'b1, 1'b0, 4'd14);
        tick();
        check("bp1_data", wb_data, 32'h11);
        check("bp1_ready", in_ready, 1'b1);
        drive(1'b1, 32'h22, 4'h0, 4'd2, 1'b1, 1'b0, 4'd14);
        tick();
        check("bp2_ready_low", in_ready, 1'b0);
        check("bp2_data_stable", wb_data, 32'h11);
        drive(1'b1, 32'h33, 4'h0, 4'd3, 1'b1, 1'b0, 4'd14);
        tick();
        check("bp3_held_ready", in_ready, 1'b0);
        check("bp3_data_stable", wb_data, 32'h11);
        check("bp3_addr_stable", wb_addr, 4'd1);
        out_ready = 1'b1;
        tick();
        check("bp_pop1_data", wb_data, 32'h22);
        check("bp_pop1_ready", in_ready, 1'b1);
        tick();
        drive(1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'd14);
        check("bp_pop2_data", wb_data, 32'h33);
        check("bp_pop2_addr", wb_addr, 4'd3);
        tick();
        check("bp_drained", out_valid, 1'b0);

        // Streaming sweep over all conditions with nzcv = 4'b1010
        drive(1'b1, 32'h0, 4'b1010, 4'd0, 1'b0, 1'b1, 4'd14);
        tick();
        check("sweep_a_nzcv", nzcv, 4'b1010);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'h100 + i, 4'h0, i[3:0], 1'b1, 1'b0, i[3:0]);
            tick();
            check($sformatf("sa_valid_%0d", i), out_valid, 1'b1);
            check($sformatf("sa_data_%0d", i), wb_data, 32'h100 + i);
            check($sformatf("sa_we_%0d", i), wb_we, pass_a[i]);
            check($sformatf("sa_ready_%0d", i), in_ready, 1'b1);
        end

        // Second sweep with nzcv = 4'b0101
        drive(1'b1, 32'h0, 4'b0101, 4'd0, 1'b0, 1'b1, 4'd14);
        tick();
        check("sweep_b_nzcv", nzcv, 4'b0101);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'h200 + i, 4'h0, i[3:0], 1'b1, 1'b0, i[3:0]);
            tick();
            check($sformatf("sb_data_%0d", i), wb_data, 32'h200 + i);
            check($sformatf("sb_we_%0d", i), wb_we, pass_b[i]);
        end
        drive(1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'd14);
        tick();
        check("sweep_drained", out_valid, 1'b0);

        // Flush with one entry and a flag-setting input: accept suppressed
        out_ready = 1'b0;
        drive(1'b1, 32'hAA, 4'h0, 4'd4, 1'b1, 1'b0, 4'd14);
        tick();
        drive(1'b1, 32'hEE, 4'b1111, 4'd8, 1'b1, 1'b1, 4'd14);
        flush = 1'b1;
        tick();
        check("flush1_valid", out_valid, 1'b0);
        check("flush1_nzcv", nzcv, 4'b0101);

        // Flush with FULL buffer and input pending
        flush = 1'b0;
        drive(1'b1, 32'hAA, 4'h0, 4'd4, 1'b1, 1'b0, 4'd14);
        tick();
        drive(1'b1, 32'hBB, 4'h0, 4'd5, 1'b1, 1'b0, 4'd14);
        tick();
        check("flush2_full", in_ready, 1'b0);
        drive(1'b1, 32'hCC, 4'b1111, 4'd7, 1'b1, 1'b1, 4'd14);
        flush = 1'b1;
        tick();
        check("flush2_valid", out_valid, 1'b0);
        check("flush2_ready", in_ready, 1'b1);
        check("flush2_nzcv", nzcv, 4'b0101);
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'd14);
        tick();
        check("flush2_no_emit", out_valid, 1'b0);
        drive(1'b1, 32'hDD, 4'h0, 4'd9, 1'b1, 1'b0, 4'd14);
        tick();
        drive(1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'd14);
        check("post_flush_data", wb_data, 32'hDD);
        check("post_flush_addr", wb_addr, 4'd9);
        tick();

        // Asynchronous reset mid-stream with nzcv = 4'b1010
        out_ready = 1'b0;
        drive(1'b1, 32'h77, 4'b1010, 4'd9, 1'b1, 1'b1, 4'd14);
        tick();
        check("ar_nzcv_set", nzcv, 4'b1010);
        drive(1'b1, 32'h78, 4'h0, 4'd10, 1'b1, 1'b0, 4'd14);
        tick();
        check("ar_full", in_ready, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", out_valid, 1'b0);
        check("ar_nzcv", nzcv, 4'b0000);
        check("ar_data", wb_data, 32'h0);
        check("ar_addr", wb_addr, 4'h0);
        check("ar_we", wb_we, 1'b0);
        drive(1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'd14);
        #1 rst_n = 1'b1;
        tick();
        check("ar_ready", in_ready, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_alu_result_stage
